int_div_regfile_unit: RTL and testbench
=======================================

Name: int_div_regfile_unit

Overview:
- Multi-cycle unsigned integer divider with a register-file write-back port.
- Accepts dividend, divisor and two destination register selects in one request.
- Computes quotient and remainder at one bit per clock, then writes both results to the register file through a req/ack handshake: quotient first, remainder second.
- Sits beside the integer ALU; the core stalls on busy.

Parameters:
- data_width, 32, width of operands, quotient and remainder.
- reg_sel_width, 5, width of register selects (index 0 = x0 = no write).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  1  start request; sampled at a rising edge only while busy=0.
- busy  output  1  high from the accept edge until the last write completes.
- r_quot_sel  input  reg_sel_width  destination register for the quotient; 0 = skip.
- r_mod_sel  input  reg_sel_width  destination register for the remainder; 0 = skip.
- a  input  data_width  dividend; captured at the accept edge.
- b  input  data_width  divisor; captured at the accept edge.
- rf_wr_sel  output  reg_sel_width  register-file write index.
- rf_wr_data  output  data_width  register-file write data.
- rf_wr_req  output  1  register-file write request.
- rf_wr_ack  input  1  register-file write acknowledge.

Behaviour:
- Reset: synchronous. At a rising edge with rst=1, the block returns to IDLE and drives busy=0, rf_wr_req=0, rf_wr_sel=0, rf_wr_data=0. Reset aborts any operation in progress; no write is issued.
- States: IDLE, CALC, WR_QUOT, WR_MOD.
- IDLE:
  - Edge with req=1: capture a, b, r_quot_sel, r_mod_sel; set busy=1.
  - If b!=0: go to CALC with iteration counter = 0.
  - If b==0: quotient = all ones and remainder = a, with no CALC cycles; go directly to the first write state, so rf_wr_req=1 appears at the accept edge itself.
  - Inputs may change after the accept edge without effect.
- CALC:
  - Restoring shift-subtract, one quotient bit per edge, MSB first. Remainder register is data_width+1 bits so no carry is lost.
  - After exactly data_width (32) edges following the accept edge, enter the first write state with rf_wr_req=1.
  - busy=1 and rf_wr_req=0 throughout CALC.
- First write state is WR_QUOT if quot_sel!=0, otherwise WR_MOD; if both selects are 0, go to IDLE (busy=0, no write).
- WR_QUOT:
  - Drive rf_wr_req=1, rf_wr_sel=quot_sel, rf_wr_data=quotient; hold stable until ack.
  - Edge with rf_wr_ack=1: go to WR_MOD if mod_sel!=0, else IDLE.
- WR_MOD:
  - Drive rf_wr_req=1, rf_wr_sel=mod_sel, rf_wr_data=remainder.
  - Edge with rf_wr_ack=1: go to IDLE with busy=0, rf_wr_req=0.
- Handshake:
  - One write completes per edge where rf_wr_req && rf_wr_ack.
  - rf_wr_ack held high continuously acknowledges consecutive writes on consecutive edges.
  - rf_wr_ack is ignored while rf_wr_req=0 (IDLE, CALC).
- Outputs: rf_wr_sel and rf_wr_data are 0 whenever rf_wr_req=0. All outputs are registered.
- req while busy=1 is ignored. A new req is accepted on the first edge after busy returns to 0.
- Arithmetic: unsigned. Examples: 0xFFFFFFFF/0xFFFFFFFD = 1 r 2; 0/x = 0 r 0.

Optional Feature:
- Macro: INT_DIV_REGFILE_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), captured at the accept edge.
  - When is_signed=1, RISC-V DIV/REM semantics apply:
    - quotient sign = sign(a) xor sign(b); remainder takes the sign of a; both are computed from operand magnitudes and negated at the end of CALC.
    - Divide by zero: quotient = -1, remainder = a.
    - Overflow (most negative value / -1): quotient = most negative value, remainder = 0, taking the zero-latency path.
  - Latency is otherwise unchanged.
- Undefined: no is_signed port; unsigned only.

Test Plan:
- 10000/123, sels 3/7 -> busy after accept, rf_wr_req rises 32 edges later with sel=3, data=81; held 2 extra cycles without ack; ack -> sel=7, data=37; ack again -> rf_wr_req=0, busy=0.
- 0/0 then 2/0, ack held high -> rf_wr_req=1 right after accept: sel=3, data=0xFFFFFFFF; next edge sel=7, data=0 (resp. 2); next edge idle.
- 4/4 -> 1 r 0; 4/2 -> 2 r 0; 0/2 -> 0 r 0; each with 32-cycle latency.
- 0xFFFFFFFF/1234567 -> 3478 r 1143269; 0xFFFFFFFF/0xFFFFFFFF -> 1 r 0; 0xFFFFFFFF/0xFFFFFFFD -> 1 r 2.
- rf_wr_ack held high while idle, and req pulsed during CALC -> no spurious write, second request ignored; r_quot_sel=0 -> only the remainder write occurs.
- rst asserted mid-CALC -> next edge: busy=0, rf_wr_req=0, no write; a subsequent request works normally.

Source files
------------

// File: rtl/int_div_regfile_unit.sv
// Unsigned restoring divider (32 cycles, 0 for divide-by-zero) writing quotient then remainder to the RF over req/ack; holds req until ack.
// Define INT_DIV_REGFILE_SIGNED_EN to add the is_signed port with RISC-V DIV/REM semantics.
module int_div_regfile_unit #(
  parameter int data_width    = 32,
  parameter int reg_sel_width = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  output logic                     busy,
  input  logic [reg_sel_width-1:0] r_quot_sel,
  input  logic [reg_sel_width-1:0] r_mod_sel,
  input  logic [data_width-1:0]    a,
  input  logic [data_width-1:0]    b,
`ifdef INT_DIV_REGFILE_SIGNED_EN
  input  logic                     is_signed,
`endif
  output logic [reg_sel_width-1:0] rf_wr_sel,
  output logic [data_width-1:0]    rf_wr_data,
  output logic                     rf_wr_req,
  input  logic                     rf_wr_ack
);

  localparam int cnt_width = $clog2(data_width);
  localparam logic [cnt_width-1:0] cnt_last = cnt_width'(data_width - 1);
  localparam logic [data_width-1:0] most_neg = {1'b1, {(data_width-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, WR_QUOT, WR_MOD} state_t;

  state_t                   state, state_n;
  logic [cnt_width-1:0]     cnt, cnt_n;
  logic [data_width-1:0]    dvd, dvd_n;
  logic [data_width:0]      rem, rem_n;
  logic [data_width-1:0]    dvs, dvs_n;
  logic [reg_sel_width-1:0] quot_sel, quot_sel_n, mod_sel, mod_sel_n;
  logic [data_width-1:0]    res_quot, res_quot_n, res_rem, res_rem_n;
  logic                     busy_n, wr_req_n;
  logic [reg_sel_width-1:0] wr_sel_n;
  logic [data_width-1:0]    wr_data_n;

  logic                     launch;
  logic [data_width-1:0]    l_quot, l_rem;
  logic [reg_sel_width-1:0] l_qsel, l_msel;
  logic [data_width+1:0]    rem_sh, diff;
  logic [data_width-1:0]    a_mag, b_mag;
  logic                     overflow;

`ifdef INT_DIV_REGFILE_SIGNED_EN
  logic neg_q, neg_q_n, neg_r, neg_r_n;
  logic a_neg, b_neg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dvd        <= '0;
      rem        <= '0;
      dvs        <= '0;
      quot_sel   <= '0;
      mod_sel    <= '0;
      res_quot   <= '0;
      res_rem    <= '0;
      busy       <= 1'b0;
      rf_wr_req  <= 1'b0;
      rf_wr_sel  <= '0;
      rf_wr_data <= '0;
`ifdef INT_DIV_REGFILE_SIGNED_EN
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dvd        <= dvd_n;
      rem        <= rem_n;
      dvs        <= dvs_n;
      quot_sel   <= quot_sel_n;
      mod_sel    <= mod_sel_n;
      res_quot   <= res_quot_n;
      res_rem    <= res_rem_n;
      busy       <= busy_n;
      rf_wr_req  <= wr_req_n;
      rf_wr_sel  <= wr_sel_n;
      rf_wr_data <= wr_data_n;
`ifdef INT_DIV_REGFILE_SIGNED_EN
      neg_q      <= neg_q_n;
      neg_r      <= neg_r_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    dvd_n      = dvd;
    rem_n      = rem;
    dvs_n      = dvs;
    quot_sel_n = quot_sel;
    mod_sel_n  = mod_sel;
    res_quot_n = res_quot;
    res_rem_n  = res_rem;
    busy_n     = busy;
    wr_req_n   = rf_wr_req;
    wr_sel_n   = rf_wr_sel;
    wr_data_n  = rf_wr_data;
    launch     = 1'b0;
    l_quot     = '0;
    l_rem      = '0;
    l_qsel     = quot_sel;
    l_msel     = mod_sel;

`ifdef INT_DIV_REGFILE_SIGNED_EN
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    a_neg    = is_signed & a[data_width-1];
    b_neg    = is_signed & b[data_width-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    overflow = is_signed && (a == most_neg) && (b == '1);
`else
    a_mag    = a;
    b_mag    = b;
    overflow = 1'b0;
`endif

    // One restoring step: a borrow out of the wide subtract means the trial bit is 0.
    rem_sh = {rem, dvd[data_width-1]};
    diff   = rem_sh - {2'b00, dvs};

    case (state)
      IDLE: begin
        if (req) begin
          quot_sel_n = r_quot_sel;
          mod_sel_n  = r_mod_sel;
          busy_n     = 1'b1;
          if (b == '0 || overflow) begin
            launch = 1'b1;
            l_qsel = r_quot_sel;
            l_msel = r_mod_sel;
            l_quot = overflow ? most_neg : '1;
            l_rem  = overflow ? '0 : a;
          end else begin
            state_n = CALC;
            cnt_n   = '0;
            dvd_n   = a_mag;
            rem_n   = '0;
            dvs_n   = b_mag;
`ifdef INT_DIV_REGFILE_SIGNED_EN
            neg_q_n = a_neg ^ b_neg;
            neg_r_n = a_neg;
`endif
          end
        end
      end
      CALC: begin
        rem_n = diff[data_width+1] ? rem_sh[data_width:0] : diff[data_width:0];
        dvd_n = {dvd[data_width-2:0], ~diff[data_width+1]};
        cnt_n = cnt + cnt_width'(1);
        if (cnt == cnt_last) begin
          launch = 1'b1;
          l_quot = dvd_n;
          l_rem  = rem_n[data_width-1:0];
`ifdef INT_DIV_REGFILE_SIGNED_EN
          if (neg_q) l_quot = -dvd_n;
          if (neg_r) l_rem  = -rem_n[data_width-1:0];
`endif
        end
      end
      WR_QUOT: begin
        if (rf_wr_ack) begin
          if (mod_sel != '0) begin
            state_n   = WR_MOD;
            wr_sel_n  = mod_sel;
            wr_data_n = res_rem;
          end else begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            wr_req_n  = 1'b0;
            wr_sel_n  = '0;
            wr_data_n = '0;
          end
        end
      end
      WR_MOD: begin
        if (rf_wr_ack) begin
          state_n   = IDLE;
          busy_n    = 1'b0;
          wr_req_n  = 1'b0;
          wr_sel_n  = '0;
          wr_data_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Shared entry into the write phase, from both the zero-latency path and the end of CALC.
    if (launch) begin
      res_quot_n = l_quot;
      res_rem_n  = l_rem;
      if (l_qsel != '0) begin
        state_n   = WR_QUOT;
        busy_n    = 1'b1;
        wr_req_n  = 1'b1;
        wr_sel_n  = l_qsel;
        wr_data_n = l_quot;
      end else if (l_msel != '0) begin
        state_n   = WR_MOD;
        busy_n    = 1'b1;
        wr_req_n  = 1'b1;
        wr_sel_n  = l_msel;
        wr_data_n = l_rem;
      end else begin
        state_n   = IDLE;
        busy_n    = 1'b0;
        wr_req_n  = 1'b0;
        wr_sel_n  = '0;
        wr_data_n = '0;
      end
    end
  end

endmodule

// File: tb/tb_int_div_regfile_unit.sv
// Directed bench for int_div_regfile_unit: latency, write-back order, handshake stalls, reset abort.
module tb_int_div_regfile_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        busy;
  logic [4:0]  r_quot_sel;
  logic [4:0]  r_mod_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rf_wr_sel;
  logic [31:0] rf_wr_data;
  logic        rf_wr_req;
  logic        rf_wr_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_div_regfile_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .busy       (busy),
    .r_quot_sel (r_quot_sel),
    .r_mod_sel  (r_mod_sel),
    .a          (a),
    .b          (b),
`ifdef INT_DIV_REGFILE_SIGNED_EN
    .is_signed  (1'b0),
`endif
    .rf_wr_sel  (rf_wr_sel),
    .rf_wr_data (rf_wr_data),
    .rf_wr_req  (rf_wr_req),
    .rf_wr_ack  (rf_wr_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge that follows the accept edge.
  task automatic start(input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] qs, input logic [4:0] ms);
    req        = 1'b1;
    a          = av;
    b          = bv;
    r_quot_sel = qs;
    r_mod_sel  = ms;
    @(negedge clk);
    req        = 1'b0;
    a          = 32'hDEADBEEF;
    b          = 32'h0;
    r_quot_sel = 5'd30;
    r_mod_sel  = 5'd31;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (rf_wr_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] q, input logic [31:0] r, input int lat);
    int n;
    string t;
    t = $sformatf("%0h/%0h", av, bv);
    rf_wr_ack = 1'b1;
    start(av, bv, 5'd3, 5'd7);
    chk({t, " busy"}, 32'(busy), 32'd1);
    wait_req(n);
    chk({t, " latency"}, 32'(n), 32'(lat));
    chk({t, " quot sel"}, 32'(rf_wr_sel), 32'd3);
    chk({t, " quot data"}, rf_wr_data, q);
    @(negedge clk);
    chk({t, " mod sel"}, 32'(rf_wr_sel), 32'd7);
    chk({t, " mod data"}, rf_wr_data, r);
    @(negedge clk);
    chk({t, " done req"}, 32'(rf_wr_req), 32'd0);
    chk({t, " done busy"}, 32'(busy), 32'd0);
    rf_wr_ack = 1'b0;
  endtask

  initial begin
    int n;
    int spur;
    rst        = 1'b1;
    req        = 1'b0;
    rf_wr_ack  = 1'b0;
    a          = '0;
    b          = '0;
    r_quot_sel = '0;
    r_mod_sel  = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset req", 32'(rf_wr_req), 32'd0);
    chk("reset sel", 32'(rf_wr_sel), 32'd0);
    chk("reset data", rf_wr_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 10000/123 with the register file stalling two cycles on the quotient write
    start(32'd10000, 32'd123, 5'd3, 5'd7);
    chk("stall busy", 32'(busy), 32'd1);
    chk("stall calc req", 32'(rf_wr_req), 32'd0);
    wait_req(n);
    chk("stall latency", 32'(n), 32'd32);
    chk("stall quot sel", 32'(rf_wr_sel), 32'd3);
    chk("stall quot data", rf_wr_data, 32'd81);
    repeat (2) @(negedge clk);
    chk("stall held req", 32'(rf_wr_req), 32'd1);
    chk("stall held sel", 32'(rf_wr_sel), 32'd3);
    chk("stall held data", rf_wr_data, 32'd81);
    rf_wr_ack = 1'b1;
    @(negedge clk);
    chk("stall mod sel", 32'(rf_wr_sel), 32'd7);
    chk("stall mod data", rf_wr_data, 32'd37);
    @(negedge clk);
    chk("stall done req", 32'(rf_wr_req), 32'd0);
    chk("stall done busy", 32'(busy), 32'd0);
    chk("stall done sel", 32'(rf_wr_sel), 32'd0);
    chk("stall done data", rf_wr_data, 32'd0);
    rf_wr_ack = 1'b0;

    run_div(32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 0);
    run_div(32'd2, 32'd0, 32'hFFFFFFFF, 32'd2, 0);
    run_div(32'd4, 32'd4, 32'd1, 32'd0, 32);
    run_div(32'd4, 32'd2, 32'd2, 32'd0, 32);
    run_div(32'd0, 32'd2, 32'd0, 32'd0, 32);
    run_div(32'hFFFFFFFF, 32'd1234567, 32'd3478, 32'd1143269, 32);
    run_div(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 32);
    run_div(32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd2, 32);

    // ack high while idle, a request pulse during CALC, and a skipped quotient write
    rf_wr_ack = 1'b1;
    spur = 0;
    repeat (3) begin
      @(negedge clk);
      if (rf_wr_req) spur++;
    end
    chk("idle ack no write", 32'(spur), 32'd0);
    start(32'd100, 32'd7, 5'd0, 5'd9);
    repeat (5) @(negedge clk);
    req        = 1'b1;
    a          = 32'd5;
    b          = 32'd1;
    r_quot_sel = 5'd4;
    r_mod_sel  = 5'd4;
    @(negedge clk);
    req = 1'b0;
    wait_req(n);
    chk("skipq latency", 32'(n + 6), 32'd32);
    chk("skipq sel", 32'(rf_wr_sel), 32'd9);
    chk("skipq data", rf_wr_data, 32'd2);
    @(negedge clk);
    chk("skipq done req", 32'(rf_wr_req), 32'd0);
    chk("skipq done busy", 32'(busy), 32'd0);
    spur = 0;
    repeat (40) begin
      @(negedge clk);
      if (rf_wr_req || busy) spur++;
    end
    chk("ignored req no activity", 32'(spur), 32'd0);
    rf_wr_ack = 1'b0;

    // reset in the middle of CALC
    start(32'd10000, 32'd123, 5'd3, 5'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort req", 32'(rf_wr_req), 32'd0);
    rst = 1'b0;
    spur = 0;
    repeat (40) begin
      @(negedge clk);
      if (rf_wr_req) spur++;
    end
    chk("abort no write", 32'(spur), 32'd0);
    run_div(32'd10000, 32'd123, 32'd81, 32'd37, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
